// File: rtl/rotation_pkg.sv
// rtl/rotation_pkg.sv - shared types, constants and Q15 trig table for the angle sequencer
package rotation_pkg;

  localparam int          ANGLE_STEPS = 32;
  localparam int          ANGLE_W     = $clog2(ANGLE_STEPS);
  localparam int          FRAC_BITS   = 15;
  localparam logic [31:0] Q_ONE       = 32'h0000_8000;

  typedef logic signed [31:0] q15_t;

  typedef enum logic [1:0] {WAIT, FETCH, LOAD} seq_state_t;

  // First quadrant of round(2^15 * sin(2*pi*i/32)), i = 0..8
  function automatic q15_t quarter_sin(input logic [3:0] i);
    case (i)
      4'd0:    return q15_t'(32'h0000_0000);
      4'd1:    return q15_t'(32'h0000_18F9);
      4'd2:    return q15_t'(32'h0000_30FC);
      4'd3:    return q15_t'(32'h0000_471D);
      4'd4:    return q15_t'(32'h0000_5A82);
      4'd5:    return q15_t'(32'h0000_6A6E);
      4'd6:    return q15_t'(32'h0000_7642);
      4'd7:    return q15_t'(32'h0000_7D8A);
      4'd8:    return q15_t'(Q_ONE);
      default: return q15_t'(32'h0000_0000);
    endcase
  endfunction

  // Fold the index into the first quadrant, then restore the sign from the half-turn bit
  function automatic q15_t rom_sin(input logic [ANGLE_W-1:0] k);
    logic [3:0] j;
    j = k[3:0];
    if (j > 4'd8) j = 4'd0 - j;
    return k[4] ? -quarter_sin(j) : quarter_sin(j);
  endfunction

  function automatic q15_t rom_cos(input logic [ANGLE_W-1:0] k);
    return rom_sin(k + 5'd8);
  endfunction

endpackage

// File: rtl/rotation_angle_sequencer_trig_rom.sv
// rtl/rotation_angle_sequencer_trig_rom.sv - synchronous one-cycle Q15 sine/cosine ROM
module trig_rom
  import rotation_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic [ANGLE_W-1:0] addr,
  output q15_t               sin_q,
  output q15_t               cos_q
);

  always_ff @(posedge CLOCK_50) begin
    sin_q <= rom_sin(addr);
    cos_q <= rom_cos(addr);
  end

endmodule

// File: rtl/rotation_angle_sequencer.sv
// rtl/rotation_angle_sequencer.sv - steps the rotation angle on frame edges and latches tear-free trig values
module rotation_angle_sequencer
  import rotation_pkg::q15_t, rotation_pkg::seq_state_t, rotation_pkg::WAIT,
         rotation_pkg::FETCH, rotation_pkg::LOAD;
#(
  parameter int ANGLE_STEPS     = 32,
  parameter int FRAMES_PER_STEP = 4,
  parameter int FRAC_BITS       = 15
) (
  input  logic                           CLOCK_50,
  input  logic                           Reset_h,
  input  logic                           vs,
  input  logic                           run,
  input  logic                           dir,
  input  logic                           step_req,
  output logic [$clog2(ANGLE_STEPS)-1:0] ANGLE_ADDRESS,
  output q15_t                           sin_out,
  output q15_t                           cos_out,
  output q15_t                           neg_sin_out,
  output logic                           trig_valid
);

  localparam int   AW        = $clog2(ANGLE_STEPS);
  localparam int   CW        = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam q15_t RESET_COS = q15_t'(32'sd1 << FRAC_BITS);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          vs_q;
  logic          frame_edge;
  logic          do_step;
  q15_t          rom_sin_q, rom_cos_q;

  assign frame_edge = vs_q & ~vs;

  trig_rom u_trig_rom (
    .CLOCK_50 (CLOCK_50),
    .addr     (ANGLE_ADDRESS),
    .sin_q    (rom_sin_q),
    .cos_q    (rom_cos_q)
  );

  always_ff @(posedge CLOCK_50 or posedge Reset_h) begin
    if (Reset_h) state_q <= WAIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = ANGLE_ADDRESS;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    do_step = 1'b0;
    // A request while paused is remembered until the next frame edge consumes it
    if (run)           pend_d = 1'b0;
    else if (step_req) pend_d = 1'b1;
    case (state_q)
      WAIT: begin
        if (frame_edge) begin
          if (run) begin
            if (cnt_q == CW'(FRAMES_PER_STEP - 1)) begin
              cnt_d   = '0;
              do_step = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            do_step = pend_q | step_req;
            pend_d  = 1'b0;
          end
          if (do_step) begin
            addr_d  = dir ? ANGLE_ADDRESS - 1'b1 : ANGLE_ADDRESS + 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH:   state_d = LOAD;
      LOAD:    state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // Reset values equal ROM entry 0, so the outputs are coherent without a fetch
  always_ff @(posedge CLOCK_50 or posedge Reset_h) begin
    if (Reset_h) begin
      ANGLE_ADDRESS <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      vs_q          <= 1'b1;
      sin_out       <= '0;
      cos_out       <= RESET_COS;
      neg_sin_out   <= '0;
      trig_valid    <= 1'b0;
    end else begin
      ANGLE_ADDRESS <= addr_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      vs_q          <= vs;
      trig_valid    <= (state_q == LOAD);
      if (state_q == LOAD) begin
        sin_out     <= rom_sin_q;
        cos_out     <= rom_cos_q;
        neg_sin_out <= q15_t'(0) - rom_sin_q;
      end
    end
  end

endmodule
